// File: rtl/bram_lut_responder.sv
// Responder for the LUT register-access port plus the datapath lookup port.
// One LUT operation per cycle: lookup, then write, then read.
module bram_lut_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 48,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  lu_req,
    input  logic [ADDR_WIDTH-1:0] lu_addr,
    output logic                  lu_ready,
    output logic                  lu_valid,
    output logic [DATA_WIDTH-1:0] lu_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [DATA_WIDTH-1:0] lut [DEPTH];
    logic [DATA_WIDTH-1:0] rd_buf;
    logic [7:0]            stall_cnt;

    logic lu_go;
    logic wr_elig;
    logic rd_elig;
    logic wr_go;
    logic rd_go;
    logic stall_inc;
    logic starve_hit;

    // Request is still high in its ack cycle, so the ack masks it there.
    always_comb begin
        lu_go      = lu_req && lu_ready;
        wr_elig    = wr_req && !wr_ack;
        rd_elig    = rd_req && !rd_ack;
        wr_go      = !lu_go && wr_elig;
        rd_go      = !lu_go && !wr_elig && rd_elig;
        stall_inc  = lu_go && (wr_elig || rd_elig);
        starve_hit = stall_inc && ((stall_cnt + 8'd1) == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            lut[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_buf    <= '0;
            rd_data   <= '0;
            lu_valid  <= 1'b0;
            lu_data   <= '0;
            lu_ready  <= 1'b1;
            stall_cnt <= 8'd0;
        end else begin
            wr_ack   <= wr_go;
            rd_ack   <= rd_go;
            rd_valid <= rd_ack;
            lu_valid <= lu_go;
            lu_ready <= !starve_hit;
            if (rd_go) begin
                rd_buf <= lut[rd_addr];
            end
            if (rd_ack) begin
                rd_data <= rd_buf;
            end
            if (lu_go) begin
                lu_data <= lut[lu_addr];
            end
            if (wr_go || rd_go) begin
                stall_cnt <= 8'd0;
            end else if (stall_inc) begin
                stall_cnt <= starve_hit ? 8'd0 : stall_cnt + 8'd1;
            end
        end
    end

endmodule
